// File: rtl/sr_latch_pkg.sv
// Shared constants, command encoding and decode helper for the clocked SR latch bank.
package sr_latch_pkg;

  // Policy applied when both set and reset are asserted
  localparam int unsigned MODE_NAND    = 0;
  localparam int unsigned MODE_SET_DOM = 1;
  localparam int unsigned MODE_RST_DOM = 2;
  localparam int unsigned MODE_HOLD    = 3;

  localparam int unsigned INV_COUNT_W = 8;
  // Filter counter width covers FILTER_CYCLES up to 15
  localparam int unsigned FILT_CNT_W  = 4;

  // Command is the active-low pin pair {s_n, r_n}
  typedef enum logic [1:0] {
    CMD_BOTH = 2'b00,
    CMD_SET  = 2'b01,
    CMD_RST  = 2'b10,
    CMD_HOLD = 2'b11
  } cmd_e;

  typedef struct packed {
    logic q;
    logic qn;
  } latch_out_t;

  // Next latch outputs for a newly accepted command
  function automatic latch_out_t decode_cmd(input cmd_e cmd, input logic q_cur,
                                            input int unsigned mode);
    latch_out_t res;
    res = '{q: q_cur, qn: ~q_cur};
    case (cmd)
      CMD_SET:  res = '{q: 1'b1, qn: 1'b0};
      CMD_RST:  res = '{q: 1'b0, qn: 1'b1};
      CMD_HOLD: res = '{q: q_cur, qn: ~q_cur};
      CMD_BOTH: begin
        case (mode)
          MODE_NAND:    res = '{q: 1'b1, qn: 1'b1};
          MODE_SET_DOM: res = '{q: 1'b1, qn: 1'b0};
          MODE_RST_DOM: res = '{q: 1'b0, qn: 1'b1};
          default:      res = '{q: q_cur, qn: ~q_cur};
        endcase
      end
      default: res = '{q: q_cur, qn: ~q_cur};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_latch_bank_filter.sv
// Per-channel 2-flop synchroniser and stability filter for one {s_n, r_n} pair.
module sr_input_filter
  import sr_latch_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_n,
  input  logic r_n,
  output cmd_e acc_cmd_c,
  output logic acc_change_c
);

  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            prev;
  logic [FILT_CNT_W-1:0] cnt;
  logic [FILT_CNT_W-1:0] cnt_next;
  cmd_e                  acc;

  // Stability count and the command accepted on the coming edge
  always_comb begin
    cnt_next = cnt;
    if (sync2 != prev) begin
      cnt_next = '0;
    end else if (cnt != FILT_CNT_W'(FILTER_CYCLES)) begin
      cnt_next = FILT_CNT_W'(cnt + 1'b1);
    end
    acc_cmd_c = acc;
    if (cnt_next == FILT_CNT_W'(FILTER_CYCLES)) begin
      acc_cmd_c = cmd_e'(sync2);
    end
    acc_change_c = (acc_cmd_c != acc);
  end

  // Synchroniser, filter state and accepted command registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      prev  <= 2'b11;
      cnt   <= '0;
      acc   <= CMD_HOLD;
    end else begin
      sync1 <= {s_n, r_n};
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_next;
      acc   <= acc_cmd_c;
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of clocked SR latches with filtered inputs, forbidden-state policy and entry tracking.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned FILTER_CYCLES = 2,
  parameter int unsigned MODE          = MODE_NAND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       s_n,
  input  logic [WIDTH-1:0]       r_n,
  input  logic                   clr_invalid,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qn,
  output logic [WIDTH-1:0]       invalid,
  output logic [INV_COUNT_W-1:0] inv_count
);

  localparam int unsigned SUM_W = INV_COUNT_W + 1;

  cmd_e                   acc_cmd [WIDTH];
  logic [WIDTH-1:0]       acc_change;
  logic [WIDTH-1:0]       entry;
  logic [WIDTH-1:0]       q_next;
  logic [WIDTH-1:0]       qn_next;
  logic [WIDTH-1:0]       invalid_next;
  logic [SUM_W-1:0]       entry_pop;
  logic [SUM_W-1:0]       count_sum;
  logic [INV_COUNT_W-1:0] inv_count_next;
  latch_out_t             dec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    sr_input_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_n         (s_n[i]),
      .r_n         (r_n[i]),
      .acc_cmd_c   (acc_cmd[i]),
      .acc_change_c(acc_change[i])
    );
  end

  // Decode each channel when its accepted command changes; flag forbidden-state entries
  always_comb begin
    q_next  = q;
    qn_next = qn;
    entry   = '0;
    dec     = '{q: 1'b0, qn: 1'b1};
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (acc_change[i]) begin
        dec        = decode_cmd(acc_cmd[i], q[i], MODE);
        q_next[i]  = dec.q;
        qn_next[i] = dec.qn;
        entry[i]   = (acc_cmd[i] == CMD_BOTH);
      end
    end
  end

  // Entry popcount into a saturating counter; entry beats a simultaneous clear
  always_comb begin
    entry_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      entry_pop = SUM_W'(entry_pop + SUM_W'(entry[i]));
    end
    count_sum      = SUM_W'(SUM_W'(inv_count) + entry_pop);
    inv_count_next = count_sum[INV_COUNT_W] ? '1 : count_sum[INV_COUNT_W-1:0];
    invalid_next   = (clr_invalid ? '0 : invalid) | entry;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      qn        <= '1;
      invalid   <= '0;
      inv_count <= '0;
    end else begin
      q         <= q_next;
      qn        <= qn_next;
      invalid   <= invalid_next;
      inv_count <= inv_count_next;
    end
  end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Clocked, parametrised successor to the team's NAND-style SR latch. Provides WIDTH independent active-low set/reset channels, each with an input synchroniser, a glitch filter and a configurable policy for the forbidden both-asserted condition. Forbidden-state entries are tracked per channel and counted globally. Used wherever asynchronous panel or button S/R pairs must become clean, registered state inside the clk domain.

## Interface
- WIDTH, 4: number of channels (1–32).
- FILTER_CYCLES, 2: consecutive stable cycles required before a synchronised command is accepted (0–15; 0 = no filter).
- MODE, 0: policy when both inputs are low.
  - 0 = NAND-compatible: q=1, qn=1.
  - 1 = set-dominant.
  - 2 = reset-dominant.
  - 3 = hold.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- s_n  in  WIDTH  per-channel set request, active-low, asynchronous to clk.
- r_n  in  WIDTH  per-channel reset request, active-low, asynchronous to clk.
- clr_invalid  in  1  one-cycle pulse; clears all invalid flags.
- q  out  WIDTH  registered channel state.
- qn  out  WIDTH  registered complement; equals ~q except in MODE 0 forbidden state.
- invalid  out  WIDTH  sticky flag: channel has accepted a both-low command.
- inv_count  out  8  saturating count of forbidden-state entries, all channels.

## Operation
- Reset (rst_n low at a rising edge):
  - q=0, qn=1, invalid=0, inv_count=0.
  - Synchroniser stages = 1 (inactive), filter counters = 0, accepted command = hold.
- Per channel, the pin pair {s_n,r_n} passes through a 2-flop synchroniser, then the filter.
- Filter:
  - The counter clears whenever the synchronised pair differs from its value on the previous cycle; otherwise it increments, saturating at FILTER_CYCLES.
  - The pair is accepted when the counter reaches FILTER_CYCLES.
  - Pulses shorter than FILTER_CYCLES cycles never reach q.
- Accepted command decode:
  - 01 (s_n=0, r_n=1) → q=1, qn=0.
  - 10 → q=0, qn=1.
  - 11 → hold.
  - 00 → MODE policy:
    - MODE 1: as set.
    - MODE 2: as reset.
    - MODE 3: hold.
    - MODE 0: q=1, qn=1.
- MODE 0 exit from 00:
  - 00 → 11: q stays 1, qn becomes 0 (deterministic resolution, no race).
  - 00 → 01 or 10: decoded normally.
- Forbidden-state entry = accepted command changes from non-00 to 00 (edge, not level).
  - On entry: invalid[i] set, and inv_count increments once per entering channel.
  - Several channels entering on the same cycle add their popcount; the result saturates at 255.
- clr_invalid clears all invalid bits. If an entry and the clear occur on the same cycle, that channel's bit ends set. inv_count is cleared only by reset.
- Channels are fully independent; no cross-channel priority.

## Timing
- Latency: a pin change first sampled at edge E appears on q/qn at edge E+2+FILTER_CYCLES. With FILTER_CYCLES=0 this is E+2.
- invalid and inv_count update on the same edge as q.
- Outputs are registered; none are combinational from inputs.
- Reset mid-operation:
  - Discards in-flight filter state.
  - After rst_n rises, held pins need the full 2+FILTER_CYCLES latency to take effect.
  - Held pins are treated as a new change, and a held 00 counts as an entry.
- clr_invalid is sampled synchronously and takes effect the next edge; no latency on clearing.

## Structure
- Package sr_latch_pkg:
  - MODE_NAND/MODE_SET_DOM/MODE_RST_DOM/MODE_HOLD constants.
  - 2-bit command encoding (CMD_SET, CMD_RST, CMD_HOLD, CMD_BOTH).
  - The INV_COUNT_W=8 constant.
- Sub-module sr_input_filter, one per channel: synchroniser plus filter counter; outputs the accepted command and a one-cycle accept-change strobe.
- Top level: generate loop of filters, per-channel decode/state registers, popcount-and-saturate counter.

## Test plan
- Reset, then s_n[0]=0 held at FILTER_CYCLES=2 → q[0]=1, qn[0]=0 exactly 4 edges after first sample; other channels stay q=0, qn=1.
- r_n[1] low pulse of 1 cycle (FILTER_CYCLES=2) → q[1] unchanged. 3-cycle pulse → q[1] clears.
- MODE 0, channel 2: 00 → q=1, qn=1, invalid[2]=1, inv_count=1. Then 11 → q=1, qn=0; 00 again → inv_count=2.
- Same 00 stimulus under MODE 1/2/3 → q=1 / q=0 / q held respectively, with qn=~q; invalid is set in all three modes.
- All four channels enter 00 on the same cycle → inv_count +4. After 64 such rounds inv_count = 255 (saturated). A clr_invalid coinciding with a new entry leaves that invalid bit = 1.
- rst_n low for 1 cycle while channel 3 is mid-filter with s_n=0 held → outputs return to reset values, then q[3]=1 at 2+FILTER_CYCLES edges after reset release.
